// File: rtl/ahbl_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_pkg
// Description : Shared AHB-Lite constants and responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_pkg;

  // Transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // Transfer sizes
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Responses
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Responder state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_LAST = 3'd2;
  localparam state_t ST_ERR1 = 3'd3;
  localparam state_t ST_ERR2 = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ahbl_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_slave_mem_if
// Description : AHB-Lite signal bundle between a master/bus and one responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahbl_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahbl_slave_mem_bytelane_dec.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_bytelane_dec
// Description : Maps (HSIZE, ADDR[1:0]) to a little-endian byte strobe and
//               flags whether the size/alignment combination is legal.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_bytelane_dec
  import ahbl_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strb,
  output logic       o_align_ok
);

  // Strobe and alignment decode; sizes above a word are never legal
  always_comb begin
    o_strb     = 4'b0000;
    o_align_ok = 1'b0;
    case (i_size)
      HSIZE_BYTE: begin
        o_strb     = 4'b0001 << i_addr_lo;
        o_align_ok = 1'b1;
      end
      HSIZE_HALF: begin
        o_strb     = 4'b0011 << i_addr_lo;
        o_align_ok = ~i_addr_lo[0];
      end
      HSIZE_WORD: begin
        o_strb     = 4'b1111;
        o_align_ok = (i_addr_lo == 2'b00);
      end
      default: begin
        o_strb     = 4'b0000;
        o_align_ok = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_slave_mem
// Description : AHB-Lite memory responder with programmable wait states,
//               byte/half/word access, read bypass and two-cycle ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [31:0] ADDR_MASK   = 32'h000F_FFFF,
  parameter int          WAIT_STATES = 0,
  parameter int          TPD         = 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahbl_slave_mem_if.slave  bus
);

  localparam int          c_off_w   = $clog2(MEM_DEPTH * 4);
  localparam int          c_idx_w   = c_off_w - 2;
  localparam logic [31:0] c_limit   = 32'(MEM_DEPTH * 4);
  localparam logic [3:0]  c_wait_ld = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_cnt;
  logic                 r_wr;
  logic [c_idx_w-1:0]   r_idx;
  logic [3:0]           r_strb;
  logic [31:0]          r_rdata;
  logic [31:0]          r_mem [MEM_DEPTH];

  logic [31:0]          w_offset;
  logic [c_idx_w-1:0]   w_idx;
  logic [3:0]           w_strb;
  logic                 w_align_ok;
  logic                 w_legal;
  logic                 w_ready_state;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_bypass;
  logic [31:0]          w_rd_word;
  logic                 w_unused;

  // HBURST is ignored and TPD only matters to behavioural models
  assign w_unused = ^{bus.HBURST, TPD[0]};

  assign w_offset = bus.HADDR & ADDR_MASK;
  assign w_idx    = w_offset[c_off_w-1:2];

  ahbl_bytelane_dec u_dec (
    .i_size     (bus.HSIZE),
    .i_addr_lo  (w_offset[1:0]),
    .o_strb     (w_strb),
    .o_align_ok (w_align_ok)
  );

  assign w_legal       = w_align_ok & (w_offset < c_limit);
  assign w_ready_state = (r_state == ST_IDLE) | (r_state == ST_LAST) | (r_state == ST_ERR2);
  assign w_accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADYIN & w_ready_state;
  assign w_commit      = (r_state == ST_LAST) & r_wr;
  assign w_bypass      = w_commit & (r_idx == w_idx);

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; completing states may pipeline a new accept
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (w_accept) begin
          if (!w_legal)             w_next = ST_ERR1;
          else if (WAIT_STATES > 0) w_next = ST_WAIT;
          else                      w_next = ST_LAST;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: w_next = (r_cnt == 4'd0) ? ST_LAST : ST_WAIT;
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
      end
      ST_ERR2: bus.HRESP = HRESP_ERROR;
      default: begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
      end
    endcase
  end

  // Wait counter and write-request latch captured at accept
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cnt  <= 4'd0;
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_strb <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_cnt  <= c_wait_ld;
        r_wr   <= w_legal & bus.HWRITE;
        r_idx  <= w_idx;
        r_strb <= w_strb;
      end else begin
        if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        if (r_state == ST_LAST)                  r_wr  <= 1'b0;
      end
    end
  end

  // RAM lane writes on the completing edge of a legal write
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Read word with lanes forwarded from a write completing on the same edge
  always_comb begin
    w_rd_word = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_bypass && r_strb[b]) w_rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
    end
  end

  // Read data register loaded only by accepted legal reads
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                               r_rdata <= 32'h0;
    else if (w_accept && w_legal && !bus.HWRITE) r_rdata <= w_rd_word;
  end

  assign bus.HRDATA = r_rdata;

endmodule
`default_nettype wire
